// File: rtl/counter_button_ctrl.sv
// counter_button_ctrl: synchronises and debounces the select and reset
// buttons, and turns each accepted press into the `sel` and `counter_rst`
// controls for the Counter block.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive cycles an input must be stable (>= 1)
//   RST_HOLD        - length of the counter_rst pulse in cycles (>= 1)
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   btn_sel         - raw select button (asynchronous, bouncy)
//   btn_rst         - raw counter-reset button (asynchronous, bouncy)
//   sel             - level, toggles on each accepted select press
//   sel_pulse       - one-cycle strobe in the cycle sel changes
//   counter_rst     - reset to Counter, high for RST_HOLD cycles
module counter_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sel,
    input  logic btn_rst,
    output logic sel,
    output logic sel_pulse,
    output logic counter_rst
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    // Bit 0 of each channel vector is the select button, bit 1 the reset.
    logic [1:0]         s1_q, s1_d;
    logic [1:0]         s2_q, s2_d;
    logic [1:0]         db_q, db_d;
    logic [1:0]         db_prev_q, db_prev_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    state_e             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               sel_q, sel_d;
    logic               pulse_q, pulse_d;
    logic               crst_q, crst_d;

    logic               press_sel;
    logic               press_rst;

    // Debounce: db only moves after s2 has disagreed with it for
    // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the run.
    always_comb begin
        s1_d      = {btn_rst, btn_sel};
        s2_d      = s1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        cnt_d     = cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (s2_q[c] == db_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_MAX) begin
                db_d[c]  = s2_q[c];
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    // Only rising edges of the debounced level count as presses.
    assign press_sel = db_q[0] & ~db_prev_q[0];
    assign press_rst = db_q[1] & ~db_prev_q[1];

    // Reset press has priority; select presses seen during HOLD are dropped.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        pulse_d = 1'b0;
        crst_d  = crst_q;
        unique case (state_q)
            IDLE: begin
                if (press_rst) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                    sel_d   = 1'b0;
                    crst_d  = 1'b1;
                end else if (press_sel) begin
                    sel_d   = ~sel_q;
                    pulse_d = 1'b1;
                end
            end
            HOLD: begin
                if (press_rst) begin
                    hold_d = HOLD_LOAD;
                end else if (hold_q == '0) begin
                    state_d = IDLE;
                    crst_d  = 1'b0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            hold_q    <= '0;
            sel_q     <= 1'b0;
            pulse_q   <= 1'b0;
            crst_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            pulse_q   <= pulse_d;
            crst_q    <= crst_d;
        end
    end

    assign sel         = sel_q;
    assign sel_pulse   = pulse_q;
    assign counter_rst = crst_q;

endmodule

// File: tb/tb_counter_button_ctrl.sv
// tb_counter_button_ctrl: three configurations of counter_button_ctrl
// (4/3, 1/6, 1/1) driven by shared button stimulus, checked against a model.
module tb_counter_button_ctrl;

    localparam int N = 3;

    int pd [N] = '{4, 1, 1};
    int ph [N] = '{3, 6, 1};

    logic clk;
    logic rst;
    logic btn_sel;
    logic btn_rst;
    logic [N-1:0] sel_o;
    logic [N-1:0] pulse_o;
    logic [N-1:0] crst_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    counter_button_ctrl #(.DEBOUNCE_CYCLES(4), .RST_HOLD(3)) u0 (
        .clk(clk), .rst(rst), .btn_sel(btn_sel), .btn_rst(btn_rst),
        .sel(sel_o[0]), .sel_pulse(pulse_o[0]), .counter_rst(crst_o[0])
    );
    counter_button_ctrl #(.DEBOUNCE_CYCLES(1), .RST_HOLD(6)) u1 (
        .clk(clk), .rst(rst), .btn_sel(btn_sel), .btn_rst(btn_rst),
        .sel(sel_o[1]), .sel_pulse(pulse_o[1]), .counter_rst(crst_o[1])
    );
    counter_button_ctrl #(.DEBOUNCE_CYCLES(1), .RST_HOLD(1)) u2 (
        .clk(clk), .rst(rst), .btn_sel(btn_sel), .btn_rst(btn_rst),
        .sel(sel_o[2]), .sel_pulse(pulse_o[2]), .counter_rst(crst_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: inputs reach s2 two edges late; the debounced level flips once
    // the last D s2 samples all disagree with it; a rising debounced level
    // is a press; a reset press arms RST_HOLD cycles of counter_rst.
    logic [1:0]  m_s1  [N] = '{default: '0};
    logic [1:0]  m_s2  [N] = '{default: '0};
    logic [1:0]  m_db  [N] = '{default: '0};
    logic [1:0]  m_dbd [N] = '{default: '0};
    logic [15:0] hs    [N] = '{default: '0};
    logic [15:0] hr    [N] = '{default: '0};
    int          m_rem [N] = '{default: 0};
    logic        m_sel [N] = '{default: 1'b0};
    logic        m_pls [N] = '{default: 1'b0};

    function automatic logic db_next(logic db, logic [15:0] h, int d);
        logic [15:0] m;
        m = 16'((32'd1 << d) - 1);
        if (db) return ((h & m) == 16'd0) ? 1'b0 : 1'b1;
        return ((h & m) == m) ? 1'b1 : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_s1[i]  <= '0;
                m_s2[i]  <= '0;
                m_db[i]  <= '0;
                m_dbd[i] <= '0;
                hs[i]    <= '0;
                hr[i]    <= '0;
                m_rem[i] <= 0;
                m_sel[i] <= 1'b0;
                m_pls[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_s1[i]  <= {btn_rst, btn_sel};
                m_s2[i]  <= m_s1[i];
                hs[i]    <= {hs[i][14:0], m_s2[i][0]};
                hr[i]    <= {hr[i][14:0], m_s2[i][1]};
                m_db[i]  <= {
                    db_next(m_db[i][1], {hr[i][14:0], m_s2[i][1]}, pd[i]),
                    db_next(m_db[i][0], {hs[i][14:0], m_s2[i][0]}, pd[i])
                };
                m_dbd[i] <= m_db[i];
                if (m_db[i][1] && !m_dbd[i][1]) begin
                    m_rem[i] <= ph[i];
                    m_sel[i] <= 1'b0;
                    m_pls[i] <= 1'b0;
                end else if (m_rem[i] > 0) begin
                    m_rem[i] <= m_rem[i] - 1;
                    m_pls[i] <= 1'b0;
                end else if (m_db[i][0] && !m_dbd[i][0]) begin
                    m_sel[i] <= ~m_sel[i];
                    m_pls[i] <= 1'b1;
                end else begin
                    m_pls[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(string nm, logic a, logic e);
        n_assert++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("c%0d u%0d sel", cyc, i), sel_o[i], m_sel[i]);
            chk($sformatf("c%0d u%0d pulse", cyc, i), pulse_o[i], m_pls[i]);
            chk($sformatf("c%0d u%0d crst", cyc, i), crst_o[i], m_rem[i] > 0);
        end
    end

    // Hand-computed expectations, applied to both DUT and model.
    task automatic lit(string nm, int i, logic es, logic ep, logic ec);
        chk({nm, " sel"}, sel_o[i], es);
        chk({nm, " pulse"}, pulse_o[i], ep);
        chk({nm, " crst"}, crst_o[i], ec);
        chk({nm, " model sel"}, m_sel[i], es);
        chk({nm, " model pulse"}, m_pls[i], ep);
        chk({nm, " model crst"}, m_rem[i] > 0, ec);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int pat [6] = '{1, 0, 1, 1, 0, 1};
    int rpat [6] = '{1, 1, 0, 0, 1, 1};

    initial begin
        btn_sel = 1'b0;
        btn_rst = 1'b0;
        rst     = 1'b1;

        // Reset with select held: toggle after full latency
        btn_sel = 1'b1;
        step(2);
        lit("rstA hold", 0, 0, 0, 0);
        rst = 1'b0;
        step(6);
        lit("rstA e5", 0, 0, 0, 0);
        step(1);
        lit("rstA e6", 0, 1, 1, 0);
        step(1);
        lit("rstA e7", 0, 1, 0, 0);
        btn_sel = 1'b0;
        step(12);

        // Reset with reset button held; sel cleared asynchronously
        btn_rst = 1'b1;
        rst = 1'b1;
        #1;
        lit("rstB async", 0, 0, 0, 0);
        chk("rstB async u1 sel", sel_o[1], 1'b0);
        step(2);
        rst = 1'b0;
        step(6);
        lit("rstB e5", 0, 0, 0, 0);
        step(1);
        lit("rstB e6", 0, 0, 0, 1);
        step(2);
        lit("rstB e8", 0, 0, 0, 1);
        step(1);
        lit("rstB e9", 0, 0, 0, 0);
        btn_rst = 1'b0;
        step(12);

        // Reset with both held: reset press wins
        rst = 1'b1;
        btn_sel = 1'b1;
        btn_rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);
        lit("rstC e5", 0, 0, 0, 0);
        step(1);
        lit("rstC e6", 0, 0, 0, 1);
        step(3);
        lit("rstC e9", 0, 0, 0, 0);
        btn_sel = 1'b0;
        btn_rst = 1'b0;
        step(12);

        // Clean select presses, release does not toggle
        btn_sel = 1'b1;
        step(6);
        lit("sel1 e5", 0, 0, 0, 0);
        step(1);
        lit("sel1 e6", 0, 1, 1, 0);
        step(1);
        lit("sel1 e7", 0, 1, 0, 0);
        step(2);
        btn_sel = 1'b0;
        step(10);
        lit("sel1 rel", 0, 1, 0, 0);
        btn_sel = 1'b1;
        step(7);
        lit("sel2 e6", 0, 0, 1, 0);
        step(3);
        btn_sel = 1'b0;
        step(10);
        lit("sel2 rel", 0, 0, 0, 0);

        // Bouncy select press
        for (int k = 0; k < 6; k++) begin
            btn_sel = (pat[k] != 0);
            step(1);
        end
        step(5);
        lit("bnc e10", 0, 0, 0, 0);
        step(1);
        lit("bnc e11", 0, 1, 1, 0);
        step(1);
        lit("bnc e12", 0, 1, 0, 0);
        btn_sel = 1'b0;
        step(12);

        // Reset pulse with sel = 1
        btn_rst = 1'b1;
        step(6);
        lit("rp e5", 0, 1, 0, 0);
        step(1);
        lit("rp e6", 0, 0, 0, 1);
        step(2);
        lit("rp e8", 0, 0, 0, 1);
        step(1);
        lit("rp e9", 0, 0, 0, 0);
        btn_rst = 1'b0;
        step(12);

        // Retrigger in HOLD (u1: presses at edges 3 and 7)
        for (int k = 0; k < 6; k++) begin
            btn_rst = (rpat[k] != 0);
            step(1);
        end
        btn_rst = 1'b0;
        step(4);
        lit("retrig e9", 1, 0, 0, 1);
        step(3);
        lit("retrig e12", 1, 0, 0, 1);
        step(1);
        lit("retrig e13", 1, 0, 0, 0);
        step(8);

        // Select press during HOLD is dropped (u1); u2 single-cycle hold
        btn_rst = 1'b1;
        step(2);
        btn_rst = 1'b0;
        step(1);
        btn_sel = 1'b1;
        step(1);
        lit("sup u2 e3", 2, 0, 0, 1);
        step(1);
        btn_sel = 1'b0;
        lit("sup u2 e4", 2, 0, 0, 0);
        step(2);
        lit("sup u1 e6", 1, 0, 0, 1);
        lit("sup u2 e6", 2, 1, 1, 0);
        step(3);
        lit("sup u1 e9", 1, 0, 0, 0);
        step(8);

        // Simultaneous press with sel = 1, then rst mid-HOLD
        btn_sel = 1'b1;
        step(7);
        lit("sim pre", 0, 1, 1, 0);
        btn_sel = 1'b0;
        step(12);
        btn_sel = 1'b1;
        btn_rst = 1'b1;
        step(6);
        lit("sim e5", 0, 1, 0, 0);
        step(1);
        lit("sim e6", 0, 0, 0, 1);
        step(1);
        lit("sim e7", 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        lit("mid rst", 0, 0, 0, 0);
        step(2);
        rst = 1'b0;
        step(6);
        lit("held e5", 0, 0, 0, 0);
        step(1);
        lit("held e6", 0, 0, 0, 1);
        btn_sel = 1'b0;
        btn_rst = 1'b0;
        step(15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_button_ctrl.md
# counter_button_ctrl

Front end that turns two raw push-buttons into the `sel` and reset controls consumed by the `Counter` block. It generates on the board what the simulation bench drives by hand. Each button is synchronised and debounced. A debounced press of the select button toggles `sel`. A debounced press of the reset button issues a fixed-length `counter_rst` pulse and clears `sel`. The block sits between the board button pins and the `Counter` instance in the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive cycles a synchronised input must differ from its debounced value before the debounced value changes. Legal range ≥ 1.
- `RST_HOLD`, default 4: length of the `counter_rst` pulse in cycles. Legal range ≥ 1.

Ports:
- `clk`, in, 1: the single clock; all state is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `btn_sel`, in, 1: raw select button, asynchronous, bouncy, active-high.
- `btn_rst`, in, 1: raw counter-reset button, asynchronous, bouncy, active-high.
- `sel`, out, 1: level output to `Counter.sel`. Toggles on each accepted select press.
- `sel_pulse`, out, 1: one-cycle strobe, high in the cycle `sel` takes its new value.
- `counter_rst`, out, 1: active-high reset to `Counter.rst`, held for `RST_HOLD` cycles.

## Operation
- Synchroniser: two flip-flops per button (`s1`, `s2`), both reset to 0.
- Debounce, one per channel:
  - State: registered `db`, reset 0, and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0.
  - If `s2 == db`, `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt + 1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `db`.
- Edge detect: `db_d` is `db` delayed one cycle, reset 0. A press is `db & ~db_d`. Releases are ignored.
- Control FSM, states IDLE and HOLD, reset state IDLE:
  - IDLE, reset-press: go to HOLD, `hold_cnt <= RST_HOLD-1`, `sel <= 0`, `counter_rst <= 1`.
  - IDLE, select-press only: `sel <= ~sel`, `sel_pulse <= 1`.
  - HOLD, reset-press: retrigger with `hold_cnt <= RST_HOLD-1`; stay in HOLD.
  - HOLD, `hold_cnt == 0` and no reset-press: go to IDLE, `counter_rst <= 0`.
  - HOLD otherwise: `hold_cnt <= hold_cnt - 1`.
  - HOLD: select presses are discarded, not queued; `sel` stays 0.
- Simultaneous select-press and reset-press in IDLE: reset wins; `sel = 0`, no `sel_pulse`.
- All outputs are registered.

## Timing
- Reset values: `sel = 0`, `sel_pulse = 0`, `counter_rst = 0`, FSM in IDLE. All internal registers are 0.
- Press latency:
  - A raw input is first sampled high at edge 0 and held.
  - `s2` is high after edge 1.
  - `db` rises at edge `1+DEBOUNCE_CYCLES`.
  - The output reacts at edge `2+DEBOUNCE_CYCLES`: `sel` toggles or `counter_rst` rises.
- Release needs the same `DEBOUNCE_CYCLES` stability. A new press needs a debounced release first.
- `counter_rst` stays high for exactly `RST_HOLD` cycles after the last accepted reset-press.
- `sel_pulse` is never high for two consecutive cycles.
- Boundary conditions:
  - `DEBOUNCE_CYCLES = 1`: `db` follows `s2` with one cycle of delay.
  - `RST_HOLD = 1`: single-cycle `counter_rst` pulse.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1`.
- Asserting `rst` mid-debounce or mid-HOLD clears everything immediately and asynchronously; `counter_rst` drops at once.
  - A button held through `rst` deassertion is seen as a new press after the full latency, since `db` restarts at 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `RST_HOLD = 3`.
- Reset: assert `rst` with both buttons high. Outputs are 0 immediately. Deassert `rst` → `sel` toggles to 1 at edge 6 after deassertion, then `counter_rst` never rises; the reset button, also held, fires the FSM instead if both. Run separately per button.
- Clean select press: `btn_sel` high from edge 0, held 10 cycles, then released 10 cycles, then repeated → `sel` 0→1 at edge 6 with `sel_pulse` that cycle; second press returns `sel` to 0; no toggle on release.
- Bounce: `btn_sel` pattern 1,0,1,1,0,1 (per cycle), then steady 1 → `sel` toggles exactly once, 6 edges after the steady-high run starts.
- Reset pulse: `btn_rst` press with `sel = 1` → `counter_rst` high exactly 3 cycles starting at edge 6; `sel` becomes 0 the same edge.
- Retrigger and suppression:
  - Second reset press accepted while in HOLD → `counter_rst` extends to 3 cycles after that press.
  - Select press accepted during HOLD → no `sel` change, no `sel_pulse`.
- Simultaneous presses and mid-operation reset:
  - Both buttons rise together → `counter_rst` pulses for 3 cycles, `sel = 0`, no `sel_pulse`.
  - `rst` asserted at cycle 2 of HOLD → `counter_rst` drops without waiting for a clock edge.
